// File: rtl/mux16_to_1.sv
// Registered 16-to-1 selector built as a four-level tree of 2-to-1 stages,
// with an optional mid-tree register after the 4:1 point (PIPE_STAGES=2).
module mux16_to_1 #(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [16*WIDTH-1:0]   in,
  input  logic [3:0]            sel,
  input  logic                  in_valid,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid
);

  function automatic logic [WIDTH-1:0] mux2(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             s);
    return s ? b : a;
  endfunction

  logic [7:0][WIDTH-1:0] lvl1_s;
  logic [3:0][WIDTH-1:0] lvl2_s;
  logic [3:0][WIDTH-1:0] lvl2_q_s;
  logic [1:0][WIDTH-1:0] lvl3_s;
  logic [WIDTH-1:0]      lvl4_s;
  logic [1:0]            sel_hi_q_s;
  logic                  valid_q_s;

  // tree levels 1 and 2 (sel[0], sel[1])
  always_comb begin
    lvl1_s = '0;
    lvl2_s = '0;
    for (int i = 0; i < 8; i++) begin
      lvl1_s[i] = mux2(in[(2*i)*WIDTH +: WIDTH], in[(2*i+1)*WIDTH +: WIDTH], sel[0]);
    end
    for (int j = 0; j < 4; j++) begin
      lvl2_s[j] = mux2(lvl1_s[2*j], lvl1_s[2*j+1], sel[1]);
    end
  end

  generate
    if (PIPE_STAGES == 2) begin : g_pipe2
      logic [3:0][WIDTH-1:0] lvl2_r;
      logic [1:0]            sel_hi_r;
      logic                  valid_mid_r;

      // mid-tree register; sel[3:2] travels with the 4:1 results
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          lvl2_r      <= '0;
          sel_hi_r    <= 2'b00;
          valid_mid_r <= 1'b0;
        end else begin
          valid_mid_r <= in_valid;
          if (in_valid) begin
            lvl2_r   <= lvl2_s;
            sel_hi_r <= sel[3:2];
          end
        end
      end

      assign lvl2_q_s   = lvl2_r;
      assign sel_hi_q_s = sel_hi_r;
      assign valid_q_s  = valid_mid_r;
    end else if (PIPE_STAGES == 1) begin : g_pipe1
      assign lvl2_q_s   = lvl2_s;
      assign sel_hi_q_s = sel[3:2];
      assign valid_q_s  = in_valid;
    end else begin : g_bad_pipe
      $error("mux16_to_1: PIPE_STAGES must be 1 or 2");
    end
  endgenerate

  // tree levels 3 and 4 (sel[2], sel[3])
  always_comb begin
    lvl3_s    = '0;
    lvl3_s[0] = mux2(lvl2_q_s[0], lvl2_q_s[1], sel_hi_q_s[0]);
    lvl3_s[1] = mux2(lvl2_q_s[2], lvl2_q_s[3], sel_hi_q_s[0]);
    lvl4_s    = mux2(lvl3_s[0], lvl3_s[1], sel_hi_q_s[1]);
  end

  // output register; data held while no valid request arrives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= valid_q_s;
      if (valid_q_s) begin
        out <= lvl4_s;
      end
    end
  end

endmodule

// File: tb/tb_mux16_to_1.sv
// Scoreboard bench for mux16_to_1: a WIDTH=1/PIPE=1 and a WIDTH=8/PIPE=2 instance,
// checked every cycle against an arithmetic reference model.
module tb_mux16_to_1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [15:0]  in1;
  logic [3:0]   sel1;
  logic         v1;
  logic [0:0]   out1;
  logic         ov1;
  logic [127:0] in2;
  logic [3:0]   sel2;
  logic         v2;
  logic [7:0]   out2;
  logic         ov2;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t       q1[$];
  exp_t       q2[$];
  logic [7:0] held1 = 8'h00;
  logic [7:0] held2 = 8'h00;
  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;

  mux16_to_1 #(.WIDTH(1), .PIPE_STAGES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in(in1), .sel(sel1), .in_valid(v1),
    .out(out1), .out_valid(ov1)
  );

  mux16_to_1 #(.WIDTH(8), .PIPE_STAGES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in(in2), .sel(sel2), .in_valid(v2),
    .out(out2), .out_valid(ov2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // reference: slice number sel of a bus of w-bit fields
  function automatic logic [7:0] ref_sel(input logic [127:0] bus, input int w, input logic [3:0] s);
    logic [127:0] t;
    logic [7:0]   m;
    t = bus >> (int'(s) * w);
    m = (w >= 8) ? 8'hFF : 8'((1 << w) - 1);
    return t[7:0] & m;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic drive(input logic va, input logic [3:0] sa, input logic [15:0] da,
                       input logic vb, input logic [3:0] sb, input logic [127:0] db);
    exp_t e;
    @(posedge clk);
    #1;
    v1 = va; sel1 = sa; in1 = da;
    v2 = vb; sel2 = sb; in2 = db;
    if (reset_n) begin
      if (va) begin
        e.d = ref_sel({112'd0, da}, 1, sa);
        e.due = cyc + 1;
        q1.push_back(e);
      end
      if (vb) begin
        e.d = ref_sel(db, 8, sb);
        e.due = cyc + 2;
        q2.push_back(e);
      end
    end
  endtask

  task automatic idle1(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 128'd0);
  endtask

  // asynchronous pulse mid-cycle; in-flight requests are discarded
  task automatic reset_pulse();
    #2;
    reset_n = 1'b0;
    v1 = 1'b0;
    v2 = 1'b0;
    #1;
    check("rst_async_out1", {7'd0, out1}, 8'h00);
    check("rst_async_ov1", {7'd0, ov1}, 8'h00);
    check("rst_async_out2", out2, 8'h00);
    check("rst_async_ov2", {7'd0, ov2}, 8'h00);
    q1.delete();
    q2.delete();
    held1 = 8'h00;
    held2 = 8'h00;
    #2;
    reset_n = 1'b1;
  endtask

  // monitor: pops the scoreboard whenever a result is due, else expects a held output
  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].due < cyc) begin
      check("late1", 8'h00, 8'h01);
      void'(q1.pop_front());
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      check("valid1", {7'd0, ov1}, 8'h01);
      check("data1", {7'd0, out1}, q1[0].d);
      held1 = q1[0].d;
      void'(q1.pop_front());
    end else begin
      check("idle_valid1", {7'd0, ov1}, 8'h00);
      check("hold1", {7'd0, out1}, held1);
    end
    if (q2.size() > 0 && q2[0].due < cyc) begin
      check("late2", 8'h00, 8'h01);
      void'(q2.pop_front());
    end
    if (q2.size() > 0 && q2[0].due == cyc) begin
      check("valid2", {7'd0, ov2}, 8'h01);
      check("data2", out2, q2[0].d);
      held2 = q2[0].d;
      void'(q2.pop_front());
    end else begin
      check("idle_valid2", {7'd0, ov2}, 8'h00);
      check("hold2", out2, held2);
    end
  end

  initial begin
    logic [127:0] pat2;
    logic [15:0]  one;
    reset_n = 1'b0;
    in1 = 16'hFFFF; sel1 = 4'd0; v1 = 1'b1;
    in2 = '1;       sel2 = 4'd15; v2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_out1", {7'd0, out1}, 8'h00);
    check("rst_hold_ov1", {7'd0, ov1}, 8'h00);
    check("rst_hold_out2", out2, 8'h00);
    check("rst_hold_ov2", {7'd0, ov2}, 8'h00);
    @(posedge clk);
    #1;
    v1 = 1'b0; v2 = 1'b0;
    reset_n = 1'b1;

    // directed WIDTH=1 cases
    drive(1'b1, 4'd0,  16'h0001, 1'b0, 4'd0, 128'd0);
    drive(1'b1, 4'd4,  16'h0000, 1'b0, 4'd0, 128'd0);
    drive(1'b1, 4'd8,  16'h0800, 1'b0, 4'd0, 128'd0);
    drive(1'b1, 4'd0,  16'h0080, 1'b0, 4'd0, 128'd0);
    drive(1'b1, 4'd11, 16'h0800, 1'b0, 4'd0, 128'd0);
    for (int k = 0; k < 16; k++) begin
      one = 16'h0001 << k;
      drive(1'b1, 4'(k), one, 1'b0, 4'd0, 128'd0);
    end
    for (int k = 0; k < 16; k++) begin
      one = ~(16'h0001 << k);
      drive(1'b1, 4'(k), one, 1'b0, 4'd0, 128'd0);
    end
    idle1(3);
    drive(1'b1, 4'd3,  16'h1009, 1'b0, 4'd0, 128'd0);
    drive(1'b1, 4'd12, 16'h1009, 1'b0, 4'd0, 128'd0);
    drive(1'b1, 4'd0,  16'h1009, 1'b0, 4'd0, 128'd0);
    drive(1'b1, 4'd3,  16'h0008, 1'b0, 4'd0, 128'd0);
    drive(1'b1, 4'd12, 16'h0008, 1'b0, 4'd0, 128'd0);
    drive(1'b1, 4'd0,  16'h0008, 1'b0, 4'd0, 128'd0);
    idle1(1);
    // result for sel=0 is now on out1; drop reset under it
    reset_pulse();
    idle1(2);

    // WIDTH=8, PIPE_STAGES=2 with input k = A0+k
    for (int k = 0; k < 16; k++) pat2[k*8 +: 8] = 8'hA0 + 8'(k);
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd15, pat2);
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd5,  pat2);
    idle1(3);
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd15, pat2);
    idle1(1);
    reset_pulse();
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd5,  pat2);
    idle1(1);
    reset_pulse();
    idle1(4);
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0,  pat2);
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd15, pat2);
    idle1(3);

    // randomized traffic on both instances
    for (int n = 0; n < 300; n++) begin
      drive(($urandom % 4) != 0, 4'($urandom), 16'($urandom),
            ($urandom % 4) != 0, 4'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
    end
    idle1(4);
    check("drain1", 8'(q1.size()), 8'h00);
    check("drain2", 8'(q2.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
